// File: rtl/tank_collision_engine.sv
// Frame-synchronous collision resolver: latches tank, wall and bullet geometry on start,
// scans one wall per cycle, then publishes tank block flags and bullet hit vectors.
module tank_collision_engine #(
    parameter int NUM_WALLS   = 8,
    parameter int NUM_BULLETS = 4,
    parameter int W           = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic [NUM_WALLS*W-1:0]   wall_x,
    input  logic [NUM_WALLS*W-1:0]   wall_y,
    input  logic [NUM_WALLS*W-1:0]   wall_w,
    input  logic [NUM_WALLS*W-1:0]   wall_h,
    input  logic [W-1:0]             tank_x,
    input  logic [W-1:0]             tank_y,
    input  logic [W-1:0]             tank_w,
    input  logic [W-1:0]             tank_h,
    input  logic [W-1:0]             tank_dx,
    input  logic [W-1:0]             tank_dy,
    input  logic [NUM_BULLETS*W-1:0] bullet_x,
    input  logic [NUM_BULLETS*W-1:0] bullet_y,
    input  logic [W-1:0]             bullet_size,
    input  logic [NUM_BULLETS-1:0]   bullet_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     block_x,
    output logic                     block_y,
    output logic [NUM_BULLETS-1:0]   bullet_wall_hit,
    output logic [NUM_BULLETS-1:0]   bullet_tank_hit,
    output logic [2:0]               dbg_state
);
    // Three guard bits keep candidate + size sums from wrapping for any W-bit inputs.
    localparam int SW = W + 3;
    localparam int CW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam logic [CW-1:0]        LAST_IDX = CW'(NUM_WALLS - 1);
    localparam logic signed [SW-1:0] SCR_W    = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] SCR_H    = SW'(SCREEN_H);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SCAN, S_TANK, S_DONE} state_t;

    function automatic logic signed [SW-1:0] u2s(input logic [W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    function automatic logic signed [SW-1:0] sx(input logic [W-1:0] v);
        return $signed({{3{v[W-1]}}, v});
    endfunction

    function automatic logic overlap(
        input logic signed [SW-1:0] ax, ay, aw, ah,
        input logic signed [SW-1:0] bx, by, bw, bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    state_t state_q, state_d;
    logic [CW-1:0]            idx_q;
    logic [NUM_WALLS*W-1:0]   wx_q, wy_q, ww_q, wh_q;
    logic [W-1:0]             tx_q, ty_q, tw_q, th_q, bsz_q;
    logic [NUM_BULLETS*W-1:0] bpx_q, bpy_q;
    logic [NUM_BULLETS-1:0]   bval_q, bw_acc_q;
    logic signed [SW-1:0]     cx_q, cy_q;
    logic                     bx_acc_q, by_acc_q;
    logic                     block_x_q, block_y_q;
    logic [NUM_BULLETS-1:0]   bullet_wall_hit_q, bullet_tank_hit_q;

    logic signed [SW-1:0]     cx_new, cy_new;
    logic                     seed_x, seed_y;
    logic [W-1:0]             cur_wx, cur_wy, cur_ww, cur_wh;
    logic                     wall_en, hit_x, hit_y;
    logic [NUM_BULLETS-1:0]   scan_bw, tank_bt;

    always_comb begin
        cx_new = u2s(tank_x) + sx(tank_dx);
        cy_new = u2s(tank_y) + sx(tank_dy);
        seed_x = cx_new[SW-1] || (cx_new + u2s(tank_w) > SCR_W);
        seed_y = cy_new[SW-1] || (cy_new + u2s(tank_h) > SCR_H);
    end

    always_comb begin
        cur_wx  = wx_q[int'(idx_q)*W +: W];
        cur_wy  = wy_q[int'(idx_q)*W +: W];
        cur_ww  = ww_q[int'(idx_q)*W +: W];
        cur_wh  = wh_q[int'(idx_q)*W +: W];
        wall_en = (|cur_ww) && (|cur_wh);
        hit_x   = wall_en && overlap(cx_q, u2s(ty_q), u2s(tw_q), u2s(th_q),
                                     u2s(cur_wx), u2s(cur_wy), u2s(cur_ww), u2s(cur_wh));
        hit_y   = wall_en && overlap(u2s(tx_q), cy_q, u2s(tw_q), u2s(th_q),
                                     u2s(cur_wx), u2s(cur_wy), u2s(cur_ww), u2s(cur_wh));
        scan_bw = '0;
        tank_bt = '0;
        for (int b = 0; b < NUM_BULLETS; b++) begin
            scan_bw[b] = wall_en && bval_q[b] &&
                overlap(u2s(bpx_q[b*W +: W]), u2s(bpy_q[b*W +: W]), u2s(bsz_q), u2s(bsz_q),
                        u2s(cur_wx), u2s(cur_wy), u2s(cur_ww), u2s(cur_wh));
            tank_bt[b] = bval_q[b] &&
                overlap(u2s(bpx_q[b*W +: W]), u2s(bpy_q[b*W +: W]), u2s(bsz_q), u2s(bsz_q),
                        u2s(tx_q), u2s(ty_q), u2s(tw_q), u2s(th_q));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LATCH;
            S_LATCH: state_d = S_SCAN;
            S_SCAN:  if (idx_q == LAST_IDX) state_d = S_TANK;
            S_TANK:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q <= '0;
            wx_q <= '0; wy_q <= '0; ww_q <= '0; wh_q <= '0;
            tx_q <= '0; ty_q <= '0; tw_q <= '0; th_q <= '0; bsz_q <= '0;
            bpx_q <= '0; bpy_q <= '0; bval_q <= '0;
            cx_q <= '0; cy_q <= '0;
            bx_acc_q <= 1'b0; by_acc_q <= 1'b0; bw_acc_q <= '0;
            block_x_q <= 1'b0; block_y_q <= 1'b0;
            bullet_wall_hit_q <= '0; bullet_tank_hit_q <= '0;
        end else begin
            case (state_q)
                S_LATCH: begin
                    idx_q <= '0;
                    wx_q <= wall_x; wy_q <= wall_y; ww_q <= wall_w; wh_q <= wall_h;
                    tx_q <= tank_x; ty_q <= tank_y; tw_q <= tank_w; th_q <= tank_h;
                    bsz_q <= bullet_size;
                    bpx_q <= bullet_x; bpy_q <= bullet_y; bval_q <= bullet_valid;
                    cx_q <= cx_new; cy_q <= cy_new;
                    bx_acc_q <= seed_x; by_acc_q <= seed_y;
                    bw_acc_q <= '0;
                end
                S_SCAN: begin
                    bx_acc_q <= bx_acc_q | hit_x;
                    by_acc_q <= by_acc_q | hit_y;
                    bw_acc_q <= bw_acc_q | scan_bw;
                    idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
                // Results are loaded on the TANK->DONE edge so they are visible alongside done.
                S_TANK: begin
                    block_x_q         <= bx_acc_q;
                    block_y_q         <= by_acc_q;
                    bullet_wall_hit_q <= bw_acc_q & bval_q;
                    bullet_tank_hit_q <= tank_bt;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign block_x         = block_x_q;
    assign block_y         = block_y_q;
    assign bullet_wall_hit = bullet_wall_hit_q;
    assign bullet_tank_hit = bullet_tank_hit_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_tank_collision_engine.sv
// Bench for tank_collision_engine: directed scenarios plus randomized frames compared
// against a geometric reference model through an expected-result queue.
module tb_tank_collision_engine;
  localparam int NW = 4;
  localparam int NB = 4;
  localparam int W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int RW = 2 + 2*NB;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic start = 1'b0;
  logic [NW*W-1:0] wall_x = '0, wall_y = '0, wall_w = '0, wall_h = '0;
  logic [W-1:0] tank_x = '0, tank_y = '0, tank_w = '0, tank_h = '0, tank_dx = '0, tank_dy = '0;
  logic [NB*W-1:0] bullet_x = '0, bullet_y = '0;
  logic [W-1:0] bullet_size = '0;
  logic [NB-1:0] bullet_valid = '0;
  logic busy, done, block_x, block_y;
  logic [NB-1:0] bullet_wall_hit, bullet_tank_hit;
  logic [2:0] dbg_state;

  int m_wx[NW], m_wy[NW], m_ww[NW], m_wh[NW];
  int m_bx[NB], m_by[NB];
  int m_tx, m_ty, m_tw, m_th, m_dx, m_dy, m_bsz;
  logic [NB-1:0] m_bval;

  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  tank_collision_engine #(
    .NUM_WALLS(NW), .NUM_BULLETS(NB), .W(W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .wall_x(wall_x), .wall_y(wall_y), .wall_w(wall_w), .wall_h(wall_h),
    .tank_x(tank_x), .tank_y(tank_y), .tank_w(tank_w), .tank_h(tank_h),
    .tank_dx(tank_dx), .tank_dy(tank_dy),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_size(bullet_size),
    .bullet_valid(bullet_valid),
    .busy(busy), .done(done), .block_x(block_x), .block_y(block_y),
    .bullet_wall_hit(bullet_wall_hit), .bullet_tank_hit(bullet_tank_hit),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit boxes_touch(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  // Reference: the tank is blocked on an axis if the moved box leaves the screen or hits any live wall.
  function automatic logic [RW-1:0] model();
    logic [NB-1:0] bw = '0;
    logic [NB-1:0] bt = '0;
    int cx = m_tx + m_dx;
    int cy = m_ty + m_dy;
    bit bx = (cx < 0) || (cx + m_tw > SCREEN_W);
    bit by = (cy < 0) || (cy + m_th > SCREEN_H);
    for (int i = 0; i < NW; i++) begin
      if (m_ww[i] == 0 || m_wh[i] == 0) continue;
      if (boxes_touch(cx, m_ty, m_tw, m_th, m_wx[i], m_wy[i], m_ww[i], m_wh[i])) bx = 1;
      if (boxes_touch(m_tx, cy, m_tw, m_th, m_wx[i], m_wy[i], m_ww[i], m_wh[i])) by = 1;
      for (int b = 0; b < NB; b++)
        if (m_bval[b] && boxes_touch(m_bx[b], m_by[b], m_bsz, m_bsz, m_wx[i], m_wy[i], m_ww[i], m_wh[i]))
          bw[b] = 1'b1;
    end
    for (int b = 0; b < NB; b++)
      bt[b] = m_bval[b] && boxes_touch(m_bx[b], m_by[b], m_bsz, m_bsz, m_tx, m_ty, m_tw, m_th);
    return {bx, by, bw, bt};
  endfunction

  // driver tasks
  task automatic drive_inputs();
    for (int i = 0; i < NW; i++) begin
      wall_x[i*W +: W] = W'(m_wx[i]);
      wall_y[i*W +: W] = W'(m_wy[i]);
      wall_w[i*W +: W] = W'(m_ww[i]);
      wall_h[i*W +: W] = W'(m_wh[i]);
    end
    for (int b = 0; b < NB; b++) begin
      bullet_x[b*W +: W] = W'(m_bx[b]);
      bullet_y[b*W +: W] = W'(m_by[b]);
    end
    tank_x = W'(m_tx); tank_y = W'(m_ty); tank_w = W'(m_tw); tank_h = W'(m_th);
    tank_dx = W'(m_dx); tank_dy = W'(m_dy);
    bullet_size = W'(m_bsz);
    bullet_valid = m_bval;
  endtask

  task automatic clear_scene();
    for (int i = 0; i < NW; i++) begin
      m_wx[i] = 0; m_wy[i] = 0; m_ww[i] = 0; m_wh[i] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_bx[b] = 0; m_by[b] = 0;
    end
    m_tx = 100; m_ty = 100; m_tw = 16; m_th = 16; m_dx = 0; m_dy = 0;
    m_bsz = 4; m_bval = '0;
  endtask

  task automatic check_result(input string tag, input logic [RW-1:0] exp);
    check({tag, "_block_x"}, block_x, exp[RW-1]);
    check({tag, "_block_y"}, block_y, exp[RW-2]);
    check({tag, "_bw_hit"}, bullet_wall_hit, exp[2*NB-1:NB]);
    check({tag, "_bt_hit"}, bullet_tank_hit, exp[NB-1:0]);
  endtask

  task automatic pulse_start();
    @(negedge Clk); start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
  endtask

  // One full frame: done must arrive NW+3 cycles after the start edge.
  task automatic run_scan(input string tag);
    int cyc;
    drive_inputs();
    exp_q.push_back(model());
    pulse_start();
    cyc = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && cyc < 30) begin
      @(posedge Clk); #1; cyc++;
    end
    check({tag, "_latency"}, cyc, NW + 3);
    check_result(tag, exp_q.pop_front());
    @(posedge Clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int cyc, ndone, done_cyc;
    logic [RW-1:0] exp;

    clear_scene();
    drive_inputs();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_block_x", block_x, 0);
    check("rst_block_y", block_y, 0);
    check("rst_bw_hit", bullet_wall_hit, 0);
    check("rst_bt_hit", bullet_tank_hit, 0);
    @(negedge Clk); Reset_n = 1'b1;

    clear_scene(); m_dx = 2;
    run_scan("free_move");

    clear_scene();
    m_wx[0] = 120; m_wy[0] = 90; m_ww[0] = 8; m_wh[0] = 40;
    m_dx = 5; m_dy = -3;
    run_scan("wall_block");
    check("wall_block_const_x", block_x, 1);

    m_dx = 4;
    run_scan("wall_touch");
    check("wall_touch_const_x", block_x, 0);

    clear_scene();
    m_tx = 2; m_ty = 470; m_dx = -3;
    run_scan("screen_edge");
    check("screen_edge_const_xy", {block_x, block_y}, 2'b11);

    clear_scene();
    m_wx[0] = 120; m_wy[0] = 90; m_ww[0] = 8; m_wh[0] = 40;
    m_bx[0] = 121; m_by[0] = 95;
    m_bx[1] = 104; m_by[1] = 104;
    m_bx[2] = 300; m_by[2] = 300;
    m_bx[3] = 122; m_by[3] = 100;
    m_bval = 4'b0111;
    run_scan("bullets");
    check("bullets_const", {bullet_wall_hit, bullet_tank_hit}, 8'b0001_0010);

    // Start pulses during SCAN and DONE are ignored; a mid-scan tank_x change is not seen.
    m_dx = 5; m_dy = -3;
    drive_inputs();
    exp_q.push_back(model());
    pulse_start();
    cyc = 1; ndone = 0; done_cyc = 0;
    while (cyc < 20) begin
      if (done) begin
        ndone++;
        done_cyc = cyc;
        exp = exp_q.pop_front();
        check_result("ignore", exp);
      end
      if (cyc == 3) begin start = 1'b1; tank_x = W'(500); end
      if (cyc == 4) start = 1'b0;
      if (cyc == 7) start = 1'b1;
      if (cyc == 8) begin
        start = 1'b0;
        check("ignore_busy_after_done", busy, 0);
      end
      @(posedge Clk); #1; cyc++;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_done_cycle", done_cyc, NW + 3);
    drive_inputs();

    // Asynchronous reset in the middle of a scan wipes results and suppresses done.
    run_scan("pre_reset");
    check("pre_reset_block_x", block_x, 1);
    pulse_start();
    repeat (3) begin @(posedge Clk); #1; end
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_block_x", block_x, 0);
    check("midrst_block_y", block_y, 0);
    check("midrst_bw_hit", bullet_wall_hit, 0);
    check("midrst_bt_hit", bullet_tank_hit, 0);
    @(negedge Clk); Reset_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_scan("post_reset");

    // randomized frames
    for (int t = 0; t < 25; t++) begin
      clear_scene();
      m_tw = int'($urandom_range(24, 8));
      m_th = int'($urandom_range(24, 8));
      m_tx = int'($urandom_range(640 - m_tw + 8, 0));
      m_ty = int'($urandom_range(480 - m_th + 8, 0));
      m_dx = int'($urandom_range(16, 0)) - 8;
      m_dy = int'($urandom_range(16, 0)) - 8;
      m_bsz = int'($urandom_range(8, 1));
      for (int i = 0; i < NW; i++) begin
        m_wx[i] = m_tx + int'($urandom_range(80, 0)) - 40;
        m_wy[i] = m_ty + int'($urandom_range(80, 0)) - 40;
        if (m_wx[i] < 0) m_wx[i] = 0;
        if (m_wy[i] < 0) m_wy[i] = 0;
        m_ww[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(40, 1));
        m_wh[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      end
      for (int b = 0; b < NB; b++) begin
        m_bx[b] = m_tx + int'($urandom_range(60, 0)) - 30;
        m_by[b] = m_ty + int'($urandom_range(60, 0)) - 30;
        if (m_bx[b] < 0) m_bx[b] = 0;
        if (m_by[b] < 0) m_by[b] = 0;
      end
      m_bval = NB'($urandom_range((1 << NB) - 1, 0));
      run_scan($sformatf("rand%0d", t));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
